// File: rtl/fft_frame_sequencer.sv
// rtl/fft_frame_sequencer.sv - packs serial samples into an FFT frame, captures the results and streams them out
module fft_frame_sequencer #(
    parameter int N_PTS   = 8,
    parameter int IN_W    = 4,
    parameter int OUT_W   = 26,
    parameter int FFT_LAT = 1
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [IN_W-1:0]            s_data,
    output logic [N_PTS*IN_W-1:0]      fft_x,
    input  logic [N_PTS*OUT_W-1:0]     fft_X,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [OUT_W-1:0]           m_data,
    output logic [$clog2(N_PTS)-1:0]   m_index,
    output logic                       m_last,
    output logic                       frame_done,
    output logic [7:0]                 frame_cnt
);
    localparam int IDX_W = $clog2(N_PTS);
    localparam int WC_W  = $clog2(FFT_LAT + 2);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PTS - 1);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_UNLOAD = 2'd2
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [IDX_W-1:0]         wr_idx;
    logic [WC_W-1:0]          wait_cnt;
    logic [N_PTS*OUT_W-1:0]   result_buf;
    logic                     load_hs;
    logic                     unload_hs;
    logic                     capture;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        m_valid   = 1'b0;
        load_hs   = 1'b0;
        unload_hs = 1'b0;
        capture   = 1'b0;
        case (state)
            ST_LOAD: begin
                s_ready = 1'b1;
                load_hs = s_valid;
                if (s_valid && (wr_idx == LAST_IDX)) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                capture = (wait_cnt == WC_W'(FFT_LAT));
                if (capture) begin
                    state_nxt = ST_UNLOAD;
                end
            end
            ST_UNLOAD: begin
                m_valid   = 1'b1;
                unload_hs = m_ready;
                if (m_ready && (m_index == LAST_IDX)) begin
                    state_nxt = ST_LOAD;
                end
            end
            default: state_nxt = ST_LOAD;
        endcase
    end

    assign m_last = m_valid && (m_index == LAST_IDX);
    assign m_data = result_buf[m_index*OUT_W +: OUT_W];

    // Indices only move on handshakes and return to zero on the frame's final transfer.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            fft_x      <= '0;
            result_buf <= '0;
            wr_idx     <= '0;
            m_index    <= '0;
            wait_cnt   <= '0;
            frame_cnt  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (load_hs) begin
                fft_x[wr_idx*IN_W +: IN_W] <= s_data;
                if (wr_idx == LAST_IDX) begin
                    wr_idx   <= '0;
                    wait_cnt <= '0;
                end else begin
                    wr_idx <= wr_idx + 1'b1;
                end
            end
            if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (capture) begin
                result_buf <= fft_X;
            end
            if (unload_hs) begin
                if (m_index == LAST_IDX) begin
                    m_index    <= '0;
                    frame_cnt  <= frame_cnt + 8'd1;
                    frame_done <= 1'b1;
                end else begin
                    m_index <= m_index + 1'b1;
                end
            end
        end
    end
endmodule
